// File: rtl/neurochip_cfg_loader.sv
// neurochip_cfg_loader: serialises configuration bytes LSB-first onto the
// neuron-array scan chain (one config_en pulse per chain bit), optionally
// rotates the chain to verify the load, then pulses reset_nn to arm the array.
// Optional feature macro: CFG_CHAIN_VERIFY_EN (rotate-back CRC-8 verify pass).
`timescale 1ns/1ps
module neurochip_cfg_loader #(
   parameter int unsigned CHAIN_LEN     = 523,
   parameter int unsigned NN_RST_CYCLES = 1,
   parameter int unsigned CNT_W         = $clog2(CHAIN_LEN + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] cfg_data,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   output logic       config_en,
   output logic       chain_bs_in,
   input  logic       chain_bs_out,
   output logic       reset_nn,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       verify_ok
);

   localparam int unsigned RST_W = (NN_RST_CYCLES > 1) ? $clog2(NN_RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(NN_RST_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
`ifdef CFG_CHAIN_VERIFY_EN
      VERIFY,
`endif
      NNRST,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bidx, bidx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic [RST_W-1:0] rcnt, rcnt_nxt;
   logic             err_nxt;
   logic             en_nxt;
   logic             bs_q;

`ifdef CFG_CHAIN_VERIFY_EN
   logic [7:0] in_crc, in_crc_nxt, out_crc, out_crc_nxt;
   logic       vok_q, vok_nxt;

   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[7] ^ b;
      return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction
`endif

   // Next-state, counters, shift register and CRC updates
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bidx_nxt  = bidx;
      shreg_nxt = shreg;
      rcnt_nxt  = rcnt;
      err_nxt   = err;
`ifdef CFG_CHAIN_VERIFY_EN
      in_crc_nxt  = in_crc;
      out_crc_nxt = out_crc;
      vok_nxt     = vok_q;
`endif
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = LOAD;
               err_nxt   = 1'b0;
`ifdef CFG_CHAIN_VERIFY_EN
               in_crc_nxt  = 8'h00;
               out_crc_nxt = 8'h00;
`endif
            end
         end
         LOAD: begin
            if (cfg_valid && cfg_ready) begin
               shreg_nxt = cfg_data;
               bidx_nxt  = 3'd0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
`ifdef CFG_CHAIN_VERIFY_EN
            in_crc_nxt = crc8_step(in_crc, shreg[0]);
`endif
            shreg_nxt = {1'b0, shreg[7:1]};
            bidx_nxt  = bidx + 3'd1;
            // chain end wins over byte end: leftover bits of the last byte are dropped
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
`ifdef CFG_CHAIN_VERIFY_EN
               state_nxt = VERIFY;
`else
               state_nxt = NNRST;
`endif
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
               if (bidx == 3'd7) begin
                  state_nxt = LOAD;
               end
            end
         end
`ifdef CFG_CHAIN_VERIFY_EN
         VERIFY: begin
            out_crc_nxt = crc8_step(out_crc, chain_bs_out);
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               vok_nxt = (in_crc == out_crc_nxt);
               if (in_crc != out_crc_nxt) begin
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = NNRST;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`endif
         NNRST: begin
            if (rcnt == RST_LAST) begin
               rcnt_nxt  = '0;
               state_nxt = DONE;
            end else begin
               rcnt_nxt = rcnt + RST_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // abort overrides whatever the active state decided, leaving verify_ok alone
      if (abort && (state != IDLE) && (state != DONE)) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         rcnt_nxt  = '0;
         err_nxt   = 1'b1;
`ifdef CFG_CHAIN_VERIFY_EN
         vok_nxt = vok_q;
`endif
      end

      en_nxt = (state_nxt == SHIFT);
`ifdef CFG_CHAIN_VERIFY_EN
      if (state_nxt == VERIFY) begin
         en_nxt = 1'b1;
      end
`endif
   end

   // State, datapath and registered outputs (decoded from the next state)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bidx      <= '0;
         shreg     <= '0;
         rcnt      <= '0;
         err       <= 1'b0;
         cfg_ready <= 1'b0;
         config_en <= 1'b0;
         bs_q      <= 1'b0;
         reset_nn  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bidx      <= bidx_nxt;
         shreg     <= shreg_nxt;
         rcnt      <= rcnt_nxt;
         err       <= err_nxt;
         cfg_ready <= (state_nxt == LOAD);
         config_en <= en_nxt;
         bs_q      <= (state_nxt == SHIFT) ? shreg_nxt[0] : 1'b0;
         reset_nn  <= (state_nxt == NNRST);
         busy      <= (state_nxt != IDLE);
         done      <= (state_nxt == DONE);
      end
   end

`ifdef CFG_CHAIN_VERIFY_EN
   // CRC accumulators and verify result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_crc  <= 8'h00;
         out_crc <= 8'h00;
         vok_q   <= 1'b1;
      end else begin
         in_crc  <= in_crc_nxt;
         out_crc <= out_crc_nxt;
         vok_q   <= vok_nxt;
      end
   end

   assign verify_ok   = vok_q;
   // during verify the chain is closed into a ring through the loader
   assign chain_bs_in = (state == VERIFY) ? chain_bs_out : bs_q;
`else
   logic unused_bs_out;
   assign unused_bs_out = chain_bs_out;
   assign verify_ok     = 1'b1;
   assign chain_bs_in   = bs_q;
`endif

endmodule

// File: tb/tb_neurochip_cfg_loader.sv
// tb_neurochip_cfg_loader: directed bench for the scan-chain loader with a
// 12-bit model chain; expected serial bits are queued as bytes are offered
// and popped as config_en cycles appear.
`timescale 1ns/1ps
module tb_neurochip_cfg_loader;

   localparam int CL = 12;
   localparam int NN = 1;
`ifdef CFG_CHAIN_VERIFY_EN
   localparam int EN_PER_LOAD = 2 * CL;
`else
   localparam int EN_PER_LOAD = CL;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] cfg_data = 8'h00;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready, config_en, chain_bs_in, chain_bs_out;
   logic       reset_nn, busy, done, err, verify_ok;

   logic [CL-1:0] chain = '0;
   logic          chain_clr = 1'b0;
   logic          stuck = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int en_total = 0;
   int nn_total = 0;
   int done_total = 0;
   int hs_total = 0;
   int nn_last = -1;
   int done_last = -1;
   int ld_en = 0;

   logic          exp_q[$];
   logic [CL-1:0] img;
   int            pushed;

   always #5 clk = ~clk;

   neurochip_cfg_loader #(
      .CHAIN_LEN(CL),
      .NN_RST_CYCLES(NN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .cfg_data(cfg_data),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .config_en(config_en),
      .chain_bs_in(chain_bs_in),
      .chain_bs_out(chain_bs_out),
      .reset_nn(reset_nn),
      .busy(busy),
      .done(done),
      .err(err),
      .verify_ok(verify_ok)
   );

   // Model of the array scan chain: element 0 takes bs_in, last element drives bs_out
   assign chain_bs_out = stuck ? 1'b0 : chain[CL-1];
   always @(posedge clk) begin
      if (chain_clr) chain <= '0;
      else if (config_en) chain <= {chain[CL-2:0], chain_bs_in};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: compares the serial stream of each load against the scoreboard
   always @(negedge clk) begin
      logic e;
      cyc++;
      if (!busy) ld_en = 0;
      else if (config_en) begin
         ld_en++;
         if (ld_en <= CL) begin
            check("shift_data_avail", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("bs_in", chain_bs_in, e);
            end
         end
      end
      if (config_en) en_total++;
      if (reset_nn) begin nn_total++; nn_last = cyc; end
      if (done) begin done_total++; done_last = cyc; end
      if (cfg_valid && cfg_ready) hs_total++;
   end

   task automatic begin_load();
      img = '0;
      pushed = 0;
      exp_q.delete();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (pushed < CL) begin
            exp_q.push_back(b[i]);
            img = {img[CL-2:0], b[i]};
            pushed++;
         end
      end
      cfg_data  = b;
      cfg_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (cfg_ready) begin ok = 1'b1; break; end
      end
      check("handshake_seen", 32'(ok), 1);
      @(posedge clk); #1 cfg_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      check("done_seen", 32'(seen), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                           input bit poke_start, input bit exp_ok);
      int en0, nn0, dn0, hs0, bad;
      en0 = en_total; nn0 = nn_total; dn0 = done_total; hs0 = hs_total;
      bad = 0;
      begin_load();
      check("err_clr_on_start", err, 0);
      send_byte(b0);
      if (poke_start) begin
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      if (gap > 0) begin
         repeat (8) @(posedge clk);
         #1;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (config_en !== 1'b0 || cfg_ready !== 1'b1) bad++;
         end
         check("gap_hold", bad, 0);
         @(posedge clk); #1;
      end
      send_byte(b1);
      wait_done();
      check("en_cycles", en_total - en0, EN_PER_LOAD);
      check("handshakes", hs_total - hs0, 2);
      check("done_pulses", done_total - dn0, 1);
      check("queue_empty", exp_q.size(), 0);
      check("busy_after", busy, 0);
      if (exp_ok) begin
         check("chain_image", chain, img);
         check("nn_cycles", nn_total - nn0, NN);
         check("done_after_nn", done_last - nn_last, 1);
         check("err_after", err, 0);
         check("verify_ok", verify_ok, 1);
      end else begin
         check("chain_flushed", chain, 0);
         check("nn_cycles_skip", nn_total - nn0, 0);
         check("err_mismatch", err, 1);
         check("verify_bad", verify_ok, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int en0, nn0, dn0;

      // reset state
      chain_clr = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cfg_ready", cfg_ready, 0);
      check("rst_config_en", config_en, 0);
      check("rst_bs_in", chain_bs_in, 0);
      check("rst_reset_nn", reset_nn, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_verify_ok", verify_ok, 1);
      @(posedge clk); #1 rst_n = 1'b1; chain_clr = 1'b0;

      // start and abort together in IDLE
      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("start_abort_busy", busy, 0);
      check("start_abort_ready", cfg_ready, 0);

      // basic load, 12 bits ending mid-byte, with start poked while busy
      run_load(8'hA5, 8'h0F, 0, 1'b1, 1'b1);
      check("image_const", chain, 12'hA5F);

      // same data with a 20-cycle idle gap between bytes
      @(posedge clk); #1 chain_clr = 1'b1;
      @(posedge clk); #1 chain_clr = 1'b0;
      run_load(8'hA5, 8'h0F, 20, 1'b0, 1'b1);
      check("gap_image_const", chain, 12'hA5F);

      // abort during the 5th shift cycle
      en0 = en_total; nn0 = nn_total; dn0 = done_total;
      begin_load();
      send_byte(8'hA5);
      repeat (4) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_config_en", config_en, 0);
      check("abort_err", err, 1);
      check("abort_reset_nn", reset_nn, 0);
      check("abort_en_cycles", en_total - en0, 5);
      repeat (10) @(negedge clk);
      check("abort_no_done", done_total - dn0, 0);
      check("abort_no_nn", nn_total - nn0, 0);
      check("abort_verify_ok", verify_ok, 1);
      exp_q.delete();
      run_load(8'h5A, 8'hC3, 0, 1'b0, 1'b1);

      // asynchronous reset in the middle of a shift
      begin_load();
      send_byte(8'h3C);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_bs_in", chain_bs_in, 0);
      check("arst_config_en", config_en, 0);
      check("arst_busy", busy, 0);
      check("arst_cfg_ready", cfg_ready, 0);
      check("arst_reset_nn", reset_nn, 0);
      check("arst_done", done, 0);
      check("arst_verify_ok", verify_ok, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      exp_q.delete();
      run_load(8'h96, 8'h07, 0, 1'b0, 1'b1);

`ifdef CFG_CHAIN_VERIFY_EN
      // verify against a chain whose output is stuck low
      stuck = 1'b1;
      run_load(8'hA5, 8'h0F, 0, 1'b0, 1'b0);
      stuck = 1'b0;
      run_load(8'hA5, 8'h0F, 0, 1'b0, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
